// File: rtl/match_game_pkg.sv
// Shared definitions for the card-matching game engine.
//   - state encodings (legacy 3-bit constants, consumed by display blocks)
//   - direction encoding and the packed move-key bundle
//   - one_hot4: true when exactly one of four key pulses is set
package match_game_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_PICK1 = 3'd1;
  localparam logic [2:0] ST_PICK2 = 3'd2;
  localparam logic [2:0] ST_SHOW  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

  typedef struct packed {
    logic up;
    logic down;
    logic left;
    logic right;
  } move_t;

  function automatic logic one_hot4(input logic [3:0] v);
    return $countones(v) == 1;
  endfunction

endpackage

// File: rtl/match_game_core_cursor_ctrl.sv
// Cursor controller: row/column registers driven by single-cycle key pulses.
// Ports:
//   clock, reset   : clock, synchronous active-high reset
//   clear          : synchronous return to cell 0 (game restart)
//   en             : moves honoured only while high
//   key_*          : move pulses; two or more in one cycle are discarded
//   cursor         : row*COLS+col
module cursor_ctrl
  import match_game_pkg::*;
#(
  parameter int ROWS = 6,
  parameter int COLS = 6,
  parameter int WRAP = 1,
  parameter int AW   = $clog2(ROWS*COLS)
)(
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          en,
  input  logic          key_up,
  input  logic          key_down,
  input  logic          key_left,
  input  logic          key_right,
  output logic [AW-1:0] cursor
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [RW-1:0] RMAX = RW'(ROWS-1);
  localparam logic [CW-1:0] CMAX = CW'(COLS-1);

  logic [RW-1:0] row, row_nx;
  logic [CW-1:0] col, col_nx;
  move_t         mv;

  assign mv = '{up: key_up, down: key_down, left: key_left, right: key_right};

  always_comb begin
    row_nx = row;
    col_nx = col;
    if (en && one_hot4(mv)) begin
      if (mv.up)
        row_nx = (row == '0)   ? ((WRAP != 0) ? RMAX : '0)   : row - RW'(1);
      else if (mv.down)
        row_nx = (row == RMAX) ? ((WRAP != 0) ? '0   : RMAX) : row + RW'(1);
      else if (mv.left)
        col_nx = (col == '0)   ? ((WRAP != 0) ? CMAX : '0)   : col - CW'(1);
      else
        col_nx = (col == CMAX) ? ((WRAP != 0) ? '0   : CMAX) : col + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      row <= '0;
      col <= '0;
    end else begin
      row <= row_nx;
      col <= col_nx;
    end
  end

  // row*COLS never exceeds N-COLS, so AW bits hold the product.
  assign cursor = AW'(row) * AW'(COLS) + AW'(col);

endmodule

// File: rtl/match_game_core.sv
// Memory card-matching game engine.
// Holds a ROWS x COLS board, moves a cursor, reveals two picks, compares them
// in the select cycle, and tracks matched pairs, attempts and game over.
// Ports:
//   clock, reset             : clock, synchronous active-high reset
//   start                    : start/restart pulse (IDLE/DONE only)
//   key_up/down/left/right   : cursor move pulses
//   key_sel                  : select pulse
//   load_en/addr/val         : board write port (IDLE/DONE only)
//   rd_addr / rd_val         : combinational display read port
//   face_up, matched         : per-cell masks
//   cursor, card1_loc, card2_loc, state, pairs, tries, game_over : status
module match_game_core
  import match_game_pkg::*;
#(
  parameter int ROWS = 6,
  parameter int COLS = 6,
  parameter int VW   = 5,
  parameter int HOLD = 50_000_000,
  parameter int WRAP = 1,
  localparam int N   = ROWS*COLS,
  localparam int AW  = $clog2(N),
  localparam int MW  = $clog2(N/2+1)
)(
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          key_up,
  input  logic          key_down,
  input  logic          key_left,
  input  logic          key_right,
  input  logic          key_sel,
  input  logic          load_en,
  input  logic [AW-1:0] load_addr,
  input  logic [VW-1:0] load_val,
  input  logic [AW-1:0] rd_addr,
  output logic [VW-1:0] rd_val,
  output logic [N-1:0]  face_up,
  output logic [N-1:0]  matched,
  output logic [AW-1:0] cursor,
  output logic [AW-1:0] card1_loc,
  output logic [AW-1:0] card2_loc,
  output logic [2:0]    state,
  output logic [MW-1:0] pairs,
  output logic [15:0]   tries,
  output logic          game_over
);

  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD-1);
  localparam logic [AW:0]   N_W       = (AW+1)'(N);
  localparam logic [MW-1:0] HALF      = MW'(N/2);

  logic [VW-1:0] board [N];
  logic [HW-1:0] hold_cnt;
  logic          idle_like, in_play, restart, load_ok, sel_ok, cmp_eq;

  assign idle_like = (state == ST_IDLE) || (state == ST_DONE);
  assign in_play   = (state == ST_PICK1) || (state == ST_PICK2) || (state == ST_SHOW);
  assign restart   = start && idle_like;
  assign load_ok   = load_en && idle_like && ({1'b0, load_addr} < N_W);
  // Select always acts on the pre-move cursor; the register still moves.
  assign sel_ok    = key_sel && !face_up[cursor];
  assign cmp_eq    = board[card1_loc] == board[cursor];

  cursor_ctrl #(.ROWS(ROWS), .COLS(COLS), .WRAP(WRAP), .AW(AW)) u_cursor (
    .clock     (clock),
    .reset     (reset),
    .clear     (restart),
    .en        (in_play),
    .key_up    (key_up),
    .key_down  (key_down),
    .key_left  (key_left),
    .key_right (key_right),
    .cursor    (cursor)
  );

  // Board contents survive reset; only the loader writes them.
  always_ff @(posedge clock) begin
    if (load_ok) board[load_addr] <= load_val;
  end

  assign rd_val = ({1'b0, rd_addr} < N_W) ? board[rd_addr] : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      card1_loc <= '0;
      card2_loc <= '0;
      face_up   <= '0;
      matched   <= '0;
      pairs     <= '0;
      tries     <= '0;
      hold_cnt  <= '0;
    end else begin
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state   <= ST_PICK1;
            face_up <= '0;
            matched <= '0;
            pairs   <= '0;
            tries   <= '0;
          end
        end
        ST_PICK1: begin
          if (sel_ok) begin
            card1_loc       <= cursor;
            face_up[cursor] <= 1'b1;
            state           <= ST_PICK2;
          end
        end
        ST_PICK2: begin
          if (sel_ok) begin
            card2_loc       <= cursor;
            face_up[cursor] <= 1'b1;
            hold_cnt        <= '0;
            if (tries != 16'hFFFF) tries <= tries + 16'd1;
            if (cmp_eq) begin
              matched[card1_loc] <= 1'b1;
              matched[cursor]    <= 1'b1;
              pairs              <= pairs + MW'(1);
              state              <= (pairs + MW'(1) == HALF) ? ST_DONE : ST_PICK1;
            end else begin
              state <= ST_SHOW;
            end
          end
        end
        ST_SHOW: begin
          // hold_cnt starts at 0 on entry, so SHOW lasts exactly HOLD cycles.
          if (hold_cnt == HOLD_LAST) begin
            face_up[card1_loc] <= 1'b0;
            face_up[card2_loc] <= 1'b0;
            state              <= ST_PICK1;
          end else begin
            hold_cnt <= hold_cnt + HW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign game_over = (state == ST_DONE);

endmodule

// File: tb/tb_match_game_core.sv
// Bench: directed 2x2 game flow, 6x6 cursor edges (wrap vs saturate),
// then randomized play on 6x6 against a behavioural game model.
module tb_match_game_core;

  localparam logic [4:0] K_UP = 5'b10000, K_DN = 5'b01000, K_LF = 5'b00100,
                         K_RT = 5'b00010, K_SEL = 5'b00001;
  localparam int HOLD_B = 3;

  int checks = 0, failures = 0;

  logic clock = 1'b0, reset;
  always #5 clock = ~clock;

  // 2x2 instance
  logic       a_start, a_load_en;
  logic [4:0] a_k;
  logic [1:0] a_load_addr, a_rd_addr, a_cur, a_c1, a_c2, a_pairs;
  logic [4:0] a_load_val, a_rd_val;
  logic [3:0] a_face, a_match;
  logic [2:0] a_state;
  logic [15:0] a_tries;
  logic       a_go;

  match_game_core #(.ROWS(2), .COLS(2), .VW(5), .HOLD(4), .WRAP(1)) dut_a (
    .clock(clock), .reset(reset), .start(a_start),
    .key_up(a_k[4]), .key_down(a_k[3]), .key_left(a_k[2]), .key_right(a_k[1]),
    .key_sel(a_k[0]), .load_en(a_load_en), .load_addr(a_load_addr),
    .load_val(a_load_val), .rd_addr(a_rd_addr), .rd_val(a_rd_val),
    .face_up(a_face), .matched(a_match), .cursor(a_cur), .card1_loc(a_c1),
    .card2_loc(a_c2), .state(a_state), .pairs(a_pairs), .tries(a_tries),
    .game_over(a_go));

  // 6x6 instances sharing inputs: W wraps, S saturates
  logic       b_start, b_load_en;
  logic [4:0] b_k;
  logic [5:0] b_load_addr, b_rd_addr, w_cur, s_cur, w_c1, w_c2, s_c1, s_c2;
  logic [4:0] b_load_val, w_rd_val, s_rd_val, w_pairs, s_pairs;
  logic [35:0] w_face, w_match, s_face, s_match;
  logic [2:0] w_state, s_state;
  logic [15:0] w_tries, s_tries;
  logic       w_go, s_go;

  match_game_core #(.ROWS(6), .COLS(6), .VW(5), .HOLD(HOLD_B), .WRAP(1)) dut_w (
    .clock(clock), .reset(reset), .start(b_start),
    .key_up(b_k[4]), .key_down(b_k[3]), .key_left(b_k[2]), .key_right(b_k[1]),
    .key_sel(b_k[0]), .load_en(b_load_en), .load_addr(b_load_addr),
    .load_val(b_load_val), .rd_addr(b_rd_addr), .rd_val(w_rd_val),
    .face_up(w_face), .matched(w_match), .cursor(w_cur), .card1_loc(w_c1),
    .card2_loc(w_c2), .state(w_state), .pairs(w_pairs), .tries(w_tries),
    .game_over(w_go));

  match_game_core #(.ROWS(6), .COLS(6), .VW(5), .HOLD(HOLD_B), .WRAP(0)) dut_s (
    .clock(clock), .reset(reset), .start(b_start),
    .key_up(b_k[4]), .key_down(b_k[3]), .key_left(b_k[2]), .key_right(b_k[1]),
    .key_sel(b_k[0]), .load_en(b_load_en), .load_addr(b_load_addr),
    .load_val(b_load_val), .rd_addr(b_rd_addr), .rd_val(s_rd_val),
    .face_up(s_face), .matched(s_match), .cursor(s_cur), .card1_loc(s_c1),
    .card2_loc(s_c2), .state(s_state), .pairs(s_pairs), .tries(s_tries),
    .game_over(s_go));

  // Behavioural model of the 6x6 game (state values are the published encodings)
  int mb [64];
  int mst, mpairs, mtries, showleft, c1, c2, wr, wc, sr, sc;
  logic [35:0] mface, mmatch;
  int r, j, tmp, la, lv;
  logic [3:0] kk;
  logic ss, stp, le;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic a_press(input logic [4:0] k);
    a_k = k;
    step();
    a_k = '0;
  endtask

  task automatic b_press(input logic [4:0] k);
    b_k = k;
    step();
    b_k = '0;
  endtask

  // Grid move on a 6x6 board; anything but a single key is discarded.
  task automatic mmove(input logic [3:0] k, input bit wrap, inout int rr, inout int cc);
    if ($countones(k) != 1) return;
    if (k[3])      rr = wrap ? (rr + 5) % 6 : ((rr > 0) ? rr - 1 : 0);
    else if (k[2]) rr = wrap ? (rr + 1) % 6 : ((rr < 5) ? rr + 1 : 5);
    else if (k[1]) cc = wrap ? (cc + 5) % 6 : ((cc > 0) ? cc - 1 : 0);
    else           cc = wrap ? (cc + 1) % 6 : ((cc < 5) ? cc + 1 : 5);
  endtask

  task automatic model_step(input logic st_i, input logic [3:0] k, input logic sel,
                            input logic le_i, input int la_i, input int lv_i);
    int pre;
    bit play;
    pre  = wr*6 + wc;
    play = (mst == 1) || (mst == 2) || (mst == 3);
    case (mst)
      0, 4: begin
        if (le_i && la_i < 36) mb[la_i] = lv_i;
        if (st_i) begin
          mst = 1; mface = '0; mmatch = '0; mpairs = 0; mtries = 0; wr = 0; wc = 0;
        end
      end
      1: if (sel && !mface[pre]) begin c1 = pre; mface[pre] = 1'b1; mst = 2; end
      2: if (sel && !mface[pre]) begin
        c2 = pre; mface[pre] = 1'b1;
        if (mtries < 65535) mtries++;
        if (mb[c1] == mb[pre]) begin
          mmatch[c1] = 1'b1; mmatch[pre] = 1'b1; mpairs++;
          mst = (mpairs == 18) ? 4 : 1;
        end else begin
          mst = 3; showleft = HOLD_B;
        end
      end
      3: begin
        showleft--;
        if (showleft == 0) begin mface[c1] = 1'b0; mface[c2] = 1'b0; mst = 1; end
      end
      default: ;
    endcase
    if (play) mmove(k, 1'b1, wr, wc);
  endtask

  initial begin
    int vals [4];
    vals = '{3, 7, 3, 7};
    reset = 1'b1;
    a_start = 0; a_load_en = 0; a_k = '0; a_load_addr = '0; a_load_val = '0; a_rd_addr = '0;
    b_start = 0; b_load_en = 0; b_k = '0; b_load_addr = '0; b_load_val = '0; b_rd_addr = '0;
    step(); step();
    reset = 1'b0;

    // ---- reset values
    check("rst_state", a_state, 0);   check("rst_cursor", a_cur, 0);
    check("rst_face", a_face, 0);     check("rst_match", a_match, 0);
    check("rst_pairs", a_pairs, 0);   check("rst_tries", a_tries, 0);
    check("rst_go", a_go, 0);         check("rst_c1", a_c1, 0);
    check("rst_c2", a_c2, 0);         check("rst_w_state", w_state, 0);

    // ---- load 2x2 board 3,7,3,7
    for (int i = 0; i < 4; i++) begin
      a_load_en = 1; a_load_addr = 2'(i); a_load_val = 5'(vals[i]); step();
    end
    a_load_en = 0;
    a_rd_addr = 2'd1; #1 check("rd_1", a_rd_val, 7);

    a_start = 1; step(); a_start = 0;
    check("start_state", a_state, 1); check("start_cursor", a_cur, 0);

    // ---- mismatch 0 (3) vs 1 (7)
    a_press(K_SEL);
    check("p1_state", a_state, 2); check("p1_face", a_face, 4'b0001); check("p1_c1", a_c1, 0);
    a_press(K_RT); check("mv_right", a_cur, 1);
    a_press(K_SEL);
    check("mis_state", a_state, 3); check("mis_face", a_face, 4'b0011);
    check("mis_tries", a_tries, 1); check("mis_c2", a_c2, 1); check("mis_match", a_match, 0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("show_cyc%0d", i), a_state, 3);
      if (i == 0) a_press(K_DN);        // moves are allowed during SHOW
      else if (i == 1) a_press(K_SEL);  // cell 3 is face-down but select is ignored
      else step();
    end
    check("show_end_state", a_state, 1); check("show_end_face", a_face, 0);
    check("show_end_cursor", a_cur, 3); check("show_end_tries", a_tries, 1);

    // ---- match 0 and 2
    a_press(K_UP); a_press(K_LF); check("back_to_0", a_cur, 0);
    a_press(K_SEL);
    a_press(K_RT); a_press(K_DN); a_press(K_LF); check("cursor_2", a_cur, 2);
    a_press(K_SEL);
    check("m_match", a_match, 4'b0101); check("m_pairs", a_pairs, 1);
    check("m_tries", a_tries, 2); check("m_state", a_state, 1); check("m_face", a_face, 4'b0101);

    // select on face-up cell in PICK1 is ignored
    a_press(K_SEL); check("p1_reselect", a_state, 1);

    a_press(K_UP); a_press(K_RT); a_press(K_SEL);
    check("p1b_state", a_state, 2); check("p1b_c1", a_c1, 1);
    a_press(K_SEL);  // reselect same face-up cell in PICK2
    check("p2_resel_state", a_state, 2); check("p2_resel_tries", a_tries, 2);
    check("p2_resel_c2", a_c2, 2);
    a_start = 1; a_load_en = 1; a_load_addr = 2'd3; a_load_val = 5'd0; step();
    a_start = 0; a_load_en = 0;
    check("p2_start_state", a_state, 2); check("p2_start_pairs", a_pairs, 1);
    a_rd_addr = 2'd3; #1 check("p2_load_ignored", a_rd_val, 7);

    a_press(K_DN); a_press(K_SEL);
    check("done_state", a_state, 4); check("done_go", a_go, 1);
    check("done_pairs", a_pairs, 2); check("done_match", a_match, 4'b1111);
    check("done_tries", a_tries, 3);
    a_press(K_LF); check("done_no_move", a_cur, 3);
    a_load_en = 1; a_load_addr = 2'd0; a_load_val = 5'd9; step(); a_load_en = 0;
    a_rd_addr = 2'd0; #1 check("done_load", a_rd_val, 9);

    a_start = 1; step(); a_start = 0;
    check("re_state", a_state, 1); check("re_face", a_face, 0); check("re_match", a_match, 0);
    check("re_pairs", a_pairs, 0); check("re_tries", a_tries, 0); check("re_cursor", a_cur, 0);
    check("re_go", a_go, 0);

    // ---- reset in the middle of SHOW (cell 0 = 9, cell 1 = 7)
    a_press(K_SEL); a_press(K_RT); a_press(K_SEL);
    check("rs_show", a_state, 3);
    step();
    reset = 1'b1; step(); reset = 1'b0;
    check("rs_state", a_state, 0); check("rs_face", a_face, 0); check("rs_cursor", a_cur, 0);
    check("rs_tries", a_tries, 0); check("rs_c1", a_c1, 0); check("rs_c2", a_c2, 0);
    step(); step(); step(); step();
    check("rs_stays_idle", a_state, 0);

    // ---- 6x6: shuffled pair board
    for (int i = 0; i < 64; i++) mb[i] = 0;
    for (int i = 0; i < 36; i++) mb[i] = i/2 + 1;
    for (int i = 35; i > 0; i--) begin
      j = $urandom_range(0, i); tmp = mb[i]; mb[i] = mb[j]; mb[j] = tmp;
    end
    for (int i = 0; i < 36; i++) begin
      b_load_en = 1; b_load_addr = 6'(i); b_load_val = 5'(mb[i]); step();
    end
    b_load_addr = 6'd40; b_load_val = 5'd31; step(); b_load_en = 0;
    b_rd_addr = 6'd40; #1 check("rd_oob", w_rd_val, 0);
    b_rd_addr = 6'd5;  #1 check("rd_5", w_rd_val, mb[5]);

    b_start = 1; step(); b_start = 0;
    check("b_start_w", w_state, 1); check("b_start_s", s_state, 1);

    b_press(K_UP);        check("wrap_up", w_cur, 30);   check("sat_up", s_cur, 0);
    b_press(K_UP | K_LF); check("two_keys_w", w_cur, 30); check("two_keys_s", s_cur, 0);
    b_press(K_DN);        check("wrap_dn", w_cur, 0);    check("sat_dn", s_cur, 6);
    b_press(K_LF);        check("wrap_lf", w_cur, 5);    check("sat_lf", s_cur, 6);
    wr = 0; wc = 5; sr = 1; sc = 0;

    // random cursor moves on both instances
    for (int i = 0; i < 300; i++) begin
      kk = ($urandom_range(0, 9) < 7) ? (4'b0001 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      mmove(kk, 1'b1, wr, wc);
      mmove(kk, 1'b0, sr, sc);
      b_press({kk, 1'b0});
      check("rnd_cur_w", w_cur, wr*6 + wc);
      check("rnd_cur_s", s_cur, sr*6 + sc);
    end

    // randomized play on the wrapping instance
    mst = 1; mface = '0; mmatch = '0; mpairs = 0; mtries = 0; showleft = 0; c1 = 0; c2 = 0;
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      kk = '0; ss = 0; stp = 0; le = 0;
      if (r < 35) ss = 1;
      else if (r < 45) begin ss = 1; kk = 4'b0001 << $urandom_range(0, 3); end
      else if (r < 80) kk = 4'b0001 << $urandom_range(0, 3);
      else if (r < 85) kk = 4'b0011 << $urandom_range(0, 2);
      else if (r < 90) stp = 1;
      else if (r < 95) le = 1;
      la = $urandom_range(0, 63); lv = $urandom_range(0, 31);
      b_k = {kk, ss}; b_start = stp; b_load_en = le;
      b_load_addr = 6'(la); b_load_val = 5'(lv);
      model_step(stp, kk, ss, le, la, lv);
      step();
      b_k = '0; b_start = 0; b_load_en = 0;
      b_rd_addr = 6'($urandom_range(0, 63));
      #1;
      check("g_state", w_state, mst);     check("g_cursor", w_cur, wr*6 + wc);
      check("g_face", w_face, mface);     check("g_match", w_match, mmatch);
      check("g_pairs", w_pairs, mpairs);  check("g_tries", w_tries, mtries);
      check("g_go", w_go, mst == 4);
      check("g_rd", w_rd_val, (b_rd_addr < 36) ? mb[b_rd_addr] : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
